// File: rtl/conv_window_feeder_pkg.sv
// rtl/conv_window_feeder_pkg.sv - shared constants and types for the conv feeder/accelerator pair
// Word format is Q8.24; a convolution window is WIN_SIZE words.
package garbot_conv_pkg;

    localparam int DATA_W   = 32;
    localparam int FRAC_W   = 24;
    localparam int WIN_SIZE = 9;

    typedef enum logic {
        ACCEPT = 1'b0,
        EMIT   = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/conv_window_feeder_if.sv
// rtl/conv_window_feeder_if.sv - pixel/weight input and accelerator-side output bundle
// master: producer of pixels/weights and consumer of dataOut (bench side)
// slave:  the feeder itself
interface conv_window_feeder_if import garbot_conv_pkg::*; #(
    parameter int DW = DATA_W
);
    logic [DW-1:0] pixIn;
    logic          pixValid;
    logic          pixReady;
    logic [DW-1:0] wIn;
    logic          wValid;
    logic          wReady;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          filter;
    logic          done;

    modport master (
        output pixIn, pixValid, wIn, wValid,
        input  pixReady, wReady, dataOut, dataValid, filter, done
    );

    modport slave (
        input  pixIn, pixValid, wIn, wValid,
        output pixReady, wReady, dataOut, dataValid, filter, done
    );
endinterface

// File: rtl/conv_window_feeder_line_buffer.sv
// rtl/conv_window_feeder_line_buffer.sv - DEPTH-word delay line advanced only when en is high
// Ports: clk, en (shift strobe), din (word in), dout (word pushed DEPTH shifts ago).
// Contents are deliberately not reset; the feeder's row gate masks stale words.
module line_buffer import garbot_conv_pkg::*; #(
    parameter int DEPTH = 32,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];
endmodule

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - raster pixel stream to 3x3 window bursts, with weight pass-through
// Ports: clk, reset (sync, active-high), bus (slave side of conv_window_feeder_if):
//   pixIn/pixValid/pixReady  pixel input, wIn/wValid/wReady weight input (frame boundary only),
//   dataOut/dataValid/filter to the accelerator (filter=1 weight, 0 window word), done end-of-frame pulse.
module conv_window_feeder import garbot_conv_pkg::*; #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = garbot_conv_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    conv_window_feeder_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [3:0]    IDX_LAST = 4'(WIN_SIZE - 1);

    feeder_state_t state, state_n;
    logic [RW-1:0] row, row_n;
    logic [CW-1:0] col, col_n;
    logic [3:0]    idx, idx_n, idx_inc;
    logic          last_win, last_win_n;
    logic          pready_q, pready_n;
    logic          wready_q, wready_n;
    logic [DATA_W-1:0] dout_q, dout_n;
    logic          dv_q, dv_n;
    logic          filt_q, filt_n;
    logic          done_q, done_n;

    logic          w_acc, p_acc, win_full;
    logic [DATA_W-1:0] above1, above2;
    // Row-major 3x3 window: [0..2] row r-2, [3..5] row r-1, [6..8] row r.
    logic [DATA_W-1:0] win [WIN_SIZE];

    // above1 is the pixel one row up at the same column, above2 two rows up.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_r1 (
        .clk (clk),
        .en  (p_acc),
        .din (bus.pixIn),
        .dout(above1)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_r2 (
        .clk (clk),
        .en  (p_acc),
        .din (above1),
        .dout(above2)
    );

    assign bus.pixReady  = pready_q;
    assign bus.wReady    = wready_q;
    assign bus.dataOut   = dout_q;
    assign bus.dataValid = dv_q;
    assign bus.filter    = filt_q;
    assign bus.done      = done_q;

    // Weight wins over a simultaneous pixel at the frame boundary.
    assign w_acc    = wready_q & bus.wValid;
    assign p_acc    = pready_q & bus.pixValid & ~w_acc;
    assign win_full = (row >= RW'(2)) && (col >= CW'(2));
    assign idx_inc  = idx + 4'd1;

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        idx_n      = idx;
        last_win_n = last_win;
        dout_n     = dout_q;
        dv_n       = 1'b0;
        filt_n     = 1'b0;
        done_n     = 1'b0;

        case (state)
            ACCEPT: begin
                if (w_acc) begin
                    dout_n = bus.wIn;
                    dv_n   = 1'b1;
                    filt_n = 1'b1;
                end else if (p_acc) begin
                    if (col == COL_LAST) begin
                        col_n = '0;
                        row_n = (row == ROW_LAST) ? '0 : row + RW'(1);
                    end else begin
                        col_n = col + CW'(1);
                    end
                    if (win_full) begin
                        state_n    = EMIT;
                        idx_n      = '0;
                        last_win_n = (row == ROW_LAST) && (col == COL_LAST);
                        // Word 0 is win[1] before this edge's shift, i.e. win[0] after it.
                        dout_n     = win[1];
                        dv_n       = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (idx == IDX_LAST) begin
                    state_n = ACCEPT;
                    idx_n   = '0;
                    done_n  = last_win;
                end else begin
                    idx_n  = idx_inc;
                    dout_n = win[idx_inc];
                    dv_n   = 1'b1;
                end
            end
            default: state_n = ACCEPT;
        endcase

        pready_n = (state_n == ACCEPT);
        wready_n = (state_n == ACCEPT) && (row_n == '0) && (col_n == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACCEPT;
            row      <= '0;
            col      <= '0;
            idx      <= '0;
            last_win <= 1'b0;
            pready_q <= 1'b0;
            wready_q <= 1'b0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            filt_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            col      <= col_n;
            idx      <= idx_n;
            last_win <= last_win_n;
            pready_q <= pready_n;
            wready_q <= wready_n;
            dout_q   <= dout_n;
            dv_q     <= dv_n;
            filt_q   <= filt_n;
            done_q   <= done_n;
        end
    end

    // Window columns slide left; stale contents are masked by the row/col >= 2 gate.
    always_ff @(posedge clk) begin
        if (p_acc) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= above2;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= above1;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= bus.pixIn;
        end
    end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - directed self-checking bench for conv_window_feeder (4x4 frame)
module tb_conv_window_feeder;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam logic [31:0] HALF = 32'h0080_0000;

    typedef struct {
        int          cyc;
        logic        f;
        logic [31:0] d;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    rec_t out_q[$];
    rec_t acc_q[$];
    int   wacc_q[$];
    int   done_q[$];
    int   run_q[$];
    int   run = 0;
    bit   post_rst = 1'b1;

    conv_window_feeder_if #(.DW(32)) bus ();

    conv_window_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dataValid) out_q.push_back('{cyc, bus.filter, bus.dataOut});
        if (bus.done) done_q.push_back(cyc);
        if (!reset && bus.wValid && bus.wReady) wacc_q.push_back(cyc);
        if (!reset && bus.pixValid && bus.pixReady && !(bus.wValid && bus.wReady))
            acc_q.push_back('{cyc, 1'b0, bus.pixIn});
        if (reset) begin
            run = 0;
            post_rst = 1'b1;
        end else if (!bus.pixReady) begin
            if (!post_rst) run++;
        end else begin
            post_rst = 1'b0;
            if (run > 0) run_q.push_back(run);
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pixValid = 1'b0;
        bus.wValid   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_pix(input int k, input int gaps);
        int n;
        for (int g = 0; g < gaps; g++) begin
            bus.pixValid = 1'b0;
            tick();
        end
        bus.pixIn    = 32'(k) << 24;
        bus.pixValid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.pixReady && n < 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (n >= 100) check($sformatf("pix%0d_timeout", k), 1, 0);
        tick();
        bus.pixValid = 1'b0;
    endtask

    function automatic logic [31:0] exp_word(input int w, input int i);
        int r, c, k;
        r = 2 + w / 2;
        c = 2 + w % 2;
        k = (r - 2 + i / 3) * W + (c - 2 + i % 3);
        return 32'(k) << 24;
    endfunction

    task automatic check_windows(input string tag, input int ob, input int ab, input int rb, input int db);
        int pix;
        check({tag, "_nwords"}, out_q.size() - ob, 36);
        check({tag, "_naccepts"}, acc_q.size() - ab, 16);
        if (acc_q.size() - ab >= 16) begin
            for (int k = 0; k < 16; k++)
                check($sformatf("%s_acc%0d", tag, k), acc_q[ab+k].d, 32'(k) << 24);
        end
        if (out_q.size() - ob >= 36 && acc_q.size() - ab >= 16) begin
            for (int w = 0; w < 4; w++) begin
                pix = (2 + w / 2) * W + 2 + w % 2;
                for (int i = 0; i < 9; i++) begin
                    check($sformatf("%s_w%0d_%0d", tag, w, i),
                          {out_q[ob+w*9+i].f, out_q[ob+w*9+i].d}, {1'b0, exp_word(w, i)});
                    check($sformatf("%s_w%0d_%0d_cyc", tag, w, i),
                          out_q[ob+w*9+i].cyc, acc_q[ab+pix].cyc + 1 + i);
                end
            end
        end
        check({tag, "_nbursts"}, run_q.size() - rb, 4);
        for (int j = rb; j < run_q.size(); j++)
            check($sformatf("%s_ready_low%0d", tag, j - rb), run_q[j], 9);
        check({tag, "_ndone"}, done_q.size() - db, 1);
        if (done_q.size() - db == 1 && acc_q.size() - ab >= 16)
            check({tag, "_done_cyc"}, done_q[db], acc_q[ab+15].cyc + 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, ab, rb, db, wb;
        bit ok;
        reset = 1'b1;
        bus.pixIn = '0;
        bus.pixValid = 1'b0;
        bus.wIn = '0;
        bus.wValid = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_pixReady", bus.pixReady, 0);
        check("rst_wReady", bus.wReady, 0);
        check("rst_dataValid", bus.dataValid, 0);
        check("rst_filter", bus.filter, 0);
        check("rst_dataOut", bus.dataOut, 0);
        check("rst_done", bus.done, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("release_pixReady_low", bus.pixReady, 0);
        tick();
        @(negedge clk);
        check("release_pixReady_high", bus.pixReady, 1);
        check("release_wReady_high", bus.wReady, 1);
        tick();

        // Weights: nine back-to-back
        ob = out_q.size();
        wb = wacc_q.size();
        ok = 1'b1;
        bus.wIn = HALF;
        bus.wValid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ok &= bus.wReady & bus.pixReady;
            tick();
        end
        bus.wValid = 1'b0;
        tick();
        tick();
        check("wt_ready_held", ok, 1);
        check("wt_naccepts", wacc_q.size() - wb, 9);
        check("wt_nwords", out_q.size() - ob, 9);
        if (out_q.size() - ob >= 9 && wacc_q.size() - wb >= 9) begin
            for (int i = 0; i < 9; i++) begin
                check($sformatf("wt%0d", i), {out_q[ob+i].f, out_q[ob+i].d}, {1'b1, HALF});
                check($sformatf("wt%0d_cyc", i), out_q[ob+i].cyc, wacc_q[wb+i] + 1);
            end
        end

        // Windows, gap-free
        ob = out_q.size(); ab = acc_q.size(); rb = run_q.size(); db = done_q.size();
        for (int k = 0; k < 16; k++) send_pix(k, 0);
        repeat (12) tick();
        check_windows("nogap", ob, ab, rb, db);

        // Windows with random input gaps (also exercises the frame wrap)
        ob = out_q.size(); ab = acc_q.size(); rb = run_q.size(); db = done_q.size();
        for (int k = 0; k < 16; k++) send_pix(k, int'($urandom_range(0, 2)));
        repeat (12) tick();
        check_windows("gaps", ob, ab, rb, db);

        // Priority at the frame boundary: weight first, pixel next cycle
        ob = out_q.size(); ab = acc_q.size(); wb = wacc_q.size();
        rb = run_q.size(); db = done_q.size();
        bus.wIn = 32'h1234_5678;
        bus.wValid = 1'b1;
        bus.pixIn = '0;
        bus.pixValid = 1'b1;
        @(negedge clk);
        check("prio_wReady", bus.wReady, 1);
        tick();
        bus.wValid = 1'b0;
        for (int k = 0; k < 16; k++) send_pix(k, 0);
        repeat (12) tick();
        check("prio_nw", wacc_q.size() - wb, 1);
        if (wacc_q.size() - wb >= 1 && acc_q.size() - ab >= 1 && out_q.size() - ob >= 1) begin
            check("prio_pix_after_w", acc_q[ab].cyc, wacc_q[wb] + 1);
            check("prio_wword", {out_q[ob].f, out_q[ob].d}, {1'b1, 32'h1234_5678});
        end
        check_windows("prio", ob + 1, ab, rb, db);

        // Reset during word 4 of the first burst
        do_reset();
        ob = out_q.size();
        for (int k = 0; k <= 10; k++) send_pix(k, 0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_dataValid", bus.dataValid, 0);
        check("midrst_nwords", out_q.size() - ob, 5);
        tick();
        do_reset();
        ob = out_q.size(); ab = acc_q.size(); rb = run_q.size(); db = done_q.size();
        for (int k = 0; k < 16; k++) send_pix(k, 0);
        repeat (12) tick();
        check_windows("afterrst", ob, ab, rb, db);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Upstream stage of `convAccelerator`. It accepts a raster-order pixel stream of Q8.24 words and buffers two image rows. For every pixel that completes a 3x3 window, it emits that window as a 9-word burst on `dataOut`/`dataValid` with `filter`=0, which is exactly the word sequence `convAccelerator` consumes. Between frames it also passes filter weights through with `filter`=1, so one port pair drives the accelerator's whole input side.

## Interface
- `IMG_W`, 32: pixels per row, must be ≥3.
- `IMG_H`, 32: rows per frame, must be ≥3.
- `DATA_W`, 32: word width, Q8.24.
- `clk` input 1: single clock, all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `pixIn` input DATA_W: pixel word.
- `pixValid` input 1: `pixIn` is valid.
- `pixReady` output 1: a pixel is accepted when `pixValid` & `pixReady`.
- `wIn` input DATA_W: filter weight word.
- `wValid` input 1: `wIn` is valid.
- `wReady` output 1: a weight is accepted when `wValid` & `wReady`.
- `dataOut` output DATA_W: word to `convAccelerator` `dataIn`.
- `dataValid` output 1: to `convAccelerator` `dataValid`.
- `filter` output 1: 1 means the word is a weight, 0 means it is a window word.
- `done` output 1: one-cycle pulse at end of frame.

## Operation
- **States:** ACCEPT, EMIT.
- **Counters:** `row` (0..IMG_H-1), `col` (0..IMG_W-1), `idx` (0..8).
- **ACCEPT state:**
  - `pixReady`=1.
  - `wReady`=1 only when `row`=0 and `col`=0 (frame boundary).
  - If `wValid` and `pixValid` are both high at the boundary, the weight wins and the pixel is not accepted that cycle.
- **Weight accept:** next cycle `dataOut`=`wIn`, `dataValid`=1, `filter`=1. Weights are not counted; the producer sends 9 per filter.
- **Pixel accept at (row, col):**
  - Shift the pixel into the window registers and the line buffers.
  - Advance `col`; on wrap, set `col`=0 and advance `row`.
  - If `row`≥2 and `col`≥2, go to EMIT with `idx`=0. Otherwise stay in ACCEPT.
- **EMIT state:**
  - Word `idx` = pixel(row-2+idx/3, col-2+idx%3), emitted in row-major order from top-left.
  - Word 8 is the pixel just accepted.
  - `dataValid`=1, `filter`=0.
  - Return to ACCEPT after `idx`=8.
- **Edges:** no padding. Each frame gives exactly (IMG_W-2)·(IMG_H-2) windows.
- **Frame end:** after accepting pixel (IMG_H-1, IMG_W-1) and emitting its window, pulse `done` and reset `row`/`col` to 0.
- **Arithmetic:** none. Words pass through bit-exact, with no sign or width change.

## Timing
- **Reset values:** `pixReady`=0, `wReady`=0, `dataValid`=0, `filter`=0, `dataOut`=0, `done`=0; state ACCEPT, counters 0.
- **After reset:** `pixReady` rises the cycle after `reset` deasserts.
- **Registered outputs:** `dataOut`, `dataValid`, `filter`, `done`.
- **Cycle numbering:** cycle 0 is the acceptance cycle (handshake sampled at the edge ending it).
- **Weight latency:** the word is visible in cycle 1. Back-to-back weights stream at 1 per cycle.
- **Window burst:**
  - Word i is visible in cycle i+1, for i=0..8.
  - `pixReady`=0 in cycles 1..9 and returns to 1 in cycle 10.
  - `dataValid` is continuous for 9 cycles with no gaps.
- **Non-window pixel:** `pixReady` stays high, giving 1 pixel/cycle throughput.
- **`done`:** high in cycle 10 of the final window, coincident with `pixReady` returning.
- **Idle output:** `dataValid`=0 whenever no word is issued. `dataOut` is don't-care when `dataValid`=0.
- **Input gaps:** `pixValid` low stalls counters and buffers, with no state change.
- **Backpressure:** `pixValid` held high through EMIT must lose or duplicate no pixel.
- **Reset mid-burst:** `dataValid` goes to 0 the next cycle, the burst is abandoned, and counters clear. Line buffer contents need no reset because the `row`≥2 gate masks them.

## Structure
- **Package `garbot_conv_pkg`:**
  - DATA_W=32, FRAC_W=24, WIN_SIZE=9.
  - Feeder state enum {ACCEPT, EMIT}.
  - Shared with `convAccelerator` updates.
- **Sub-module `line_buffer`:** IMG_W-deep, DATA_W-wide delay line, advanced only on pixel accept. Two are instantiated, for rows r-1 and r-2.
- **Top level:** holds the 3x3 window registers, counters, FSM and output mux.

## Test plan
All scenarios use IMG_W=IMG_H=4, with pixel k (raster index) = k<<24.
- **Windows:** stream 16 pixels with `pixValid` held high.
  - Exactly 4 bursts.
  - First burst after pixel 10: integers 0,1,2,4,5,6,8,9,10.
  - Last burst after pixel 15: 5,6,7,9,10,11,13,14,15.
  - `done` pulses once, in cycle 10 of the last burst.
- **Weights:** after reset, 9 weights of 0x00800000 (0.5) on consecutive cycles.
  - 9 consecutive `dataValid`=1, `filter`=1 cycles, each 0x00800000, 1-cycle latency.
  - `pixReady` stays 1.
- **Backpressure:** during each burst, `pixReady`=0 for exactly 9 cycles; the 16 distinct pixels are each accepted once.
- **Gaps:** insert random `pixValid`=0 cycles; window words are identical to the gap-free run.
- **Priority:** `wValid` and `pixValid` both high at the frame boundary; the weight is taken, then the pixel the next cycle.
- **Reset mid-burst:** assert `reset` at word 4 of the first burst.
  - `dataValid`=0 next cycle.
  - Re-streaming 16 pixels reproduces the scenario 1 results.
